// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: shared state encoding and phase width for the clock-enable sequencer
package clk_seq_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLDOFF, RUN} state_t;
  localparam int PHASE_W = 3;
endpackage

// File: rtl/clock_enable_sequencer_if.sv
// clock_enable_sequencer_if: lock/clear inputs and reset/strobe outputs of the sequencer
interface clock_enable_sequencer_if;
  import clk_seq_pkg::*;
  logic pll_lock;
  logic clr_lost;
  logic sys_rst_n;
  logic ce_div2;
  logic ce_div4;
  logic ce_div8;
  logic [PHASE_W-1:0] phase;
  logic running;
  logic lock_lost;
  modport master (output pll_lock, clr_lost,
                  input sys_rst_n, ce_div2, ce_div4, ce_div8, phase, running, lock_lost);
  modport slave (input pll_lock, clr_lost,
                 output sys_rst_n, ce_div2, ce_div4, ce_div8, phase, running, lock_lost);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: multi-stage synchroniser for an asynchronous single-bit input, resets to 0
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/clock_enable_sequencer.sv
// clock_enable_sequencer: lock-qualified reset release and /2,/4,/8 enable strobes on one clock
module clock_enable_sequencer
  import clk_seq_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input logic clk,
  input logic rst_n,
  clock_enable_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);
  state_t state;
  logic lock_s;
  logic run_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PHASE_W-1:0] phase_nxt;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d(bus.pll_lock),
    .q(lock_s)
  );
  // outputs are registered from next-state values so strobes stop on the same edge sys_rst_n falls
  always_comb begin
    run_nxt   = lock_s && (state == RUN || (state == HOLDOFF && cnt == CNT_W'(HOLDOFF_CYCLES - 1)));
    phase_nxt = (state == RUN && lock_s) ? bus.phase + PHASE_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      bus.sys_rst_n <= 1'b0;
      bus.running   <= 1'b0;
      bus.phase     <= '0;
      bus.ce_div2   <= 1'b0;
      bus.ce_div4   <= 1'b0;
      bus.ce_div8   <= 1'b0;
      bus.lock_lost <= 1'b0;
    end else begin
      state         <= !lock_s ? WAIT_LOCK : run_nxt ? RUN : HOLDOFF;
      cnt           <= (state == HOLDOFF && lock_s && !run_nxt) ? cnt + CNT_W'(1) : '0;
      bus.sys_rst_n <= run_nxt;
      bus.running   <= run_nxt;
      bus.phase     <= phase_nxt;
      bus.ce_div2   <= run_nxt & phase_nxt[0];
      bus.ce_div4   <= run_nxt & (&phase_nxt[1:0]);
      bus.ce_div8   <= run_nxt & (&phase_nxt);
      bus.lock_lost <= (state != WAIT_LOCK && !lock_s) || (bus.lock_lost && !bus.clr_lost);
    end
endmodule

// File: tb/tb_clock_enable_sequencer.sv
// tb_clock_enable_sequencer: hand-derived vector table, corner sequences and a streak-based reference model
module tb_clock_enable_sequencer;
  localparam int H = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  clock_enable_sequencer_if bus();
  clock_enable_sequencer #(.HOLDOFF_CYCLES(H), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  // reference model: two sampled lock bits, length of the current lock_s streak, sticky flag
  bit [1:0] hist;
  int streak;
  bit m_lost;
  typedef struct {
    bit lock;
    bit clr;
    int n;
    bit e_run;
    bit e_lost;
    bit [2:0] e_ph;
  } vec_t;
  vec_t tbl[21];
  assert property (@(posedge clk) !bus.sys_rst_n |-> !(bus.ce_div2 || bus.ce_div4 || bus.ce_div8));
  function automatic logic [8:0] dut_out();
    return {bus.sys_rst_n, bus.running, bus.ce_div2, bus.ce_div4, bus.ce_div8, bus.phase, bus.lock_lost};
  endfunction
  function automatic logic [8:0] model_out();
    bit run = streak > H;
    bit [2:0] ph = run ? 3'((streak - H - 1) % 8) : 3'd0;
    return {run, run, run & ph[0], run & (ph[1:0] == 2'd3), run & (ph == 3'd7), ph, m_lost};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist   = '0;
    streak = 0;
    m_lost = 1'b0;
  endtask
  task automatic tick();
    bit ls;
    bit set;
    @(posedge clk);
    ls     = hist[1];
    hist   = {hist[0], bus.pll_lock};
    set    = !ls && streak > 0;
    streak = ls ? streak + 1 : 0;
    m_lost = set || (m_lost && !bus.clr_lost);
    @(negedge clk);
    check("model", dut_out(), model_out());
  endtask
  initial begin
    int c2, c4, c8, coin, k, len;
    tbl = '{
      '{1, 0, 18, 0, 0, 0}, '{1, 0, 1, 1, 0, 0}, '{1, 0, 7, 1, 0, 7}, '{1, 0, 1, 1, 0, 0},
      '{0, 0, 1, 1, 0, 1},  '{0, 0, 1, 1, 0, 2}, '{0, 0, 1, 0, 1, 0}, '{1, 1, 1, 0, 0, 0},
      '{1, 0, 17, 0, 0, 0}, '{1, 0, 1, 1, 0, 0}, '{1, 0, 10, 1, 0, 2}, '{0, 1, 1, 1, 0, 3},
      '{1, 1, 1, 1, 0, 4},  '{1, 1, 1, 0, 1, 0}, '{1, 1, 1, 0, 0, 0}, '{1, 0, 8, 0, 0, 0},
      '{0, 0, 1, 0, 0, 0},  '{1, 0, 1, 0, 0, 0}, '{1, 0, 1, 0, 1, 0}, '{1, 0, 16, 0, 1, 0},
      '{1, 0, 1, 1, 1, 0}
    };
    bus.pll_lock = 1'b1;
    bus.clr_lost = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_out(), 9'd0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      bus.pll_lock = tbl[i].lock;
      bus.clr_lost = tbl[i].clr;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), {bus.sys_rst_n, bus.lock_lost, bus.phase},
            {tbl[i].e_run, tbl[i].e_lost, tbl[i].e_ph});
    end
    bus.clr_lost = 1'b0;
    c2 = 0; c4 = 0; c8 = 0; coin = 0;
    repeat (64) begin
      tick();
      c2 += int'(bus.ce_div2);
      c4 += int'(bus.ce_div4);
      c8 += int'(bus.ce_div8);
      coin += int'(bus.ce_div2 && bus.ce_div4 && bus.ce_div8 && bus.phase == 3'd7);
    end
    check("ce_div2_count", c2, 32);
    check("ce_div4_count", c4, 16);
    check("ce_div8_count", c8, 8);
    check("ce_coincide", coin, 8);
    k = 0;
    while (bus.phase != 3'd5 && k < 16) begin
      tick();
      k++;
    end
    check("reach_phase5", bus.phase, 3'd5);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), 9'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!bus.sys_rst_n && k < 40) begin
      tick();
      k++;
    end
    check("release_edges", k, 19);
    check("running_at_release", bus.running, 1'b1);
    len = 0;
    repeat (10000) begin
      tick();
      #($urandom_range(1, 3));
      if (len == 0) begin
        bus.pll_lock = ~bus.pll_lock;
        len = bus.pll_lock ? $urandom_range(1, 60) : $urandom_range(1, 4);
      end
      len--;
      bus.clr_lost = ($urandom_range(0, 15) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
